// File: rtl/pixel_pair_process.sv
// Two-stage point-operation pipeline (bright add/sub, invert, threshold) on RGB888 pixel pairs,
// framed by an IDLE/RUN/DRAIN/DONE sequencer. Define PIXEL_PROC_SAT_COUNT_EN to add sat_count.
module pixel_pair_process #(
    parameter int WIDTH     = 768,
    parameter int HEIGHT    = 512,
    parameter int THRESHOLD = 90
) (
    input  logic                              HCLK,
    input  logic                              HRESET,
    input  logic                              start,
    input  logic [1:0]                        mode,
    input  logic [7:0]                        bright_val,
    input  logic                              in_valid,
    input  logic [7:0]                        DATA_IN_R0,
    input  logic [7:0]                        DATA_IN_G0,
    input  logic [7:0]                        DATA_IN_B0,
    input  logic [7:0]                        DATA_IN_R1,
    input  logic [7:0]                        DATA_IN_G1,
    input  logic [7:0]                        DATA_IN_B1,
    output logic                              hsync,
    output logic [7:0]                        DATA_WRITE_R0,
    output logic [7:0]                        DATA_WRITE_G0,
    output logic [7:0]                        DATA_WRITE_B0,
    output logic [7:0]                        DATA_WRITE_R1,
    output logic [7:0]                        DATA_WRITE_G1,
    output logic [7:0]                        DATA_WRITE_B1,
    output logic                              busy,
    output logic                              frame_done,
`ifdef PIXEL_PROC_SAT_COUNT_EN
    output logic [$clog2(WIDTH*HEIGHT*6)-1:0] sat_count,
`endif
    output logic [$clog2(WIDTH/2)-1:0]        col_idx,
    output logic [$clog2(HEIGHT)-1:0]         row_idx
);
    localparam int PAIRS = WIDTH * HEIGHT / 2;
    localparam int CNT_W = $clog2(PAIRS);
    localparam int COL_W = $clog2(WIDTH / 2);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [9:0] THR3 = 10'(3 * THRESHOLD);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_INV = 2'b10;

    function automatic logic [7:0] chan_op(input logic [1:0] m, input logic [7:0] c, input logic [7:0] b);
        logic [8:0] sum9;
        logic [8:0] dif9;
        logic [7:0] r;
        sum9 = {1'b0, c} + {1'b0, b};
        dif9 = {1'b0, c} - {1'b0, b};
        case (m)
            MODE_ADD: r = sum9[8] ? 8'hFF : sum9[7:0];
            MODE_SUB: r = dif9[8] ? 8'h00 : dif9[7:0];
            MODE_INV: r = 8'hFF - c;
            default:  r = 8'h00;
        endcase
        return r;
    endfunction

    // A carry out of the add, or a borrow out of the subtract, marks a saturated channel.
    function automatic logic chan_sat(input logic [1:0] m, input logic [7:0] c, input logic [7:0] b);
        logic [8:0] sum9;
        logic [8:0] dif9;
        logic       s;
        sum9 = {1'b0, c} + {1'b0, b};
        dif9 = {1'b0, c} - {1'b0, b};
        case (m)
            MODE_ADD: s = sum9[8];
            MODE_SUB: s = dif9[8];
            default:  s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] pix_thr(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [9:0] s;
        s = {2'b00, r} + {2'b00, g} + {2'b00, b};
        return (s > THR3) ? 8'hFF : 8'h00;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [7:0]       bright_q, bright_d;
    logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
    logic             s1_valid_q, s1_valid_d;
    logic [47:0]      s1_pix_q, s1_pix_d;
    logic             hsync_q, hsync_d;
    logic [47:0]      dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic [COL_W-1:0] out_col_q, out_col_d, col_idx_q, col_idx_d;
    logic [ROW_W-1:0] out_row_q, out_row_d, row_idx_q, row_idx_d;
    logic             accept_start_s, accept_pair_s, last_pair_s;
    logic [7:0]       thr0_s, thr1_s;
`ifdef PIXEL_PROC_SAT_COUNT_EN
    localparam int SAT_W = $clog2(WIDTH * HEIGHT * 6);
    logic [2:0]       s1_sat_q, s1_sat_d;
    logic [SAT_W-1:0] sat_cnt_q, sat_cnt_d;
`endif

    assign accept_start_s = (state_q == ST_IDLE) && start;
    assign accept_pair_s  = (state_q == ST_RUN) && in_valid;
    assign last_pair_s    = (pair_cnt_q == CNT_W'(PAIRS - 1));
    assign thr0_s         = pix_thr(DATA_IN_R0, DATA_IN_G0, DATA_IN_B0);
    assign thr1_s         = pix_thr(DATA_IN_R1, DATA_IN_G1, DATA_IN_B1);

    // Frame sequencer, per-frame operation latch and input pair counter.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        bright_d   = bright_q;
        pair_cnt_d = pair_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    mode_d     = mode;
                    bright_d   = bright_val;
                    pair_cnt_d = {CNT_W{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    pair_cnt_d = pair_cnt_q + CNT_W'(1);
                    state_d    = last_pair_s ? ST_DRAIN : ST_RUN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            // Leave once nothing remains in flight after this edge.
            ST_DRAIN: begin
                if (!s1_valid_d && !hsync_d) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d       = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        frame_done_d = (state_d == ST_DONE);
    end

    // Stage 1: per-channel operation on the accepted pair.
    always_comb begin
        s1_valid_d = accept_pair_s;
        s1_pix_d   = s1_pix_q;
`ifdef PIXEL_PROC_SAT_COUNT_EN
        s1_sat_d   = s1_sat_q;
`endif
        if (accept_pair_s) begin
            if (mode_q == 2'b11) begin
                s1_pix_d = {thr0_s, thr0_s, thr0_s, thr1_s, thr1_s, thr1_s};
            end else begin
                s1_pix_d = {chan_op(mode_q, DATA_IN_R0, bright_q), chan_op(mode_q, DATA_IN_G0, bright_q),
                            chan_op(mode_q, DATA_IN_B0, bright_q), chan_op(mode_q, DATA_IN_R1, bright_q),
                            chan_op(mode_q, DATA_IN_G1, bright_q), chan_op(mode_q, DATA_IN_B1, bright_q)};
            end
`ifdef PIXEL_PROC_SAT_COUNT_EN
            s1_sat_d = {2'b00, chan_sat(mode_q, DATA_IN_R0, bright_q)} + {2'b00, chan_sat(mode_q, DATA_IN_G0, bright_q)}
                     + {2'b00, chan_sat(mode_q, DATA_IN_B0, bright_q)} + {2'b00, chan_sat(mode_q, DATA_IN_R1, bright_q)}
                     + {2'b00, chan_sat(mode_q, DATA_IN_G1, bright_q)} + {2'b00, chan_sat(mode_q, DATA_IN_B1, bright_q)};
`endif
        end else begin
            s1_pix_d = s1_pix_q;
        end
    end

    // Stage 2: output register plus output-side pair position.
    always_comb begin
        hsync_d   = s1_valid_q;
        dout_d    = dout_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        if (accept_start_s) begin
            out_col_d = {COL_W{1'b0}};
            out_row_d = {ROW_W{1'b0}};
            col_idx_d = {COL_W{1'b0}};
            row_idx_d = {ROW_W{1'b0}};
        end else if (s1_valid_q) begin
            dout_d    = s1_pix_q;
            col_idx_d = out_col_q;
            row_idx_d = out_row_q;
            if (out_col_q == COL_W'(WIDTH / 2 - 1)) begin
                out_col_d = {COL_W{1'b0}};
                out_row_d = (out_row_q == ROW_W'(HEIGHT - 1)) ? {ROW_W{1'b0}} : out_row_q + ROW_W'(1);
            end else begin
                out_col_d = out_col_q + COL_W'(1);
            end
        end else begin
            dout_d = dout_q;
        end
    end

`ifdef PIXEL_PROC_SAT_COUNT_EN
    // Saturation tally accumulates with each output pair and holds between frames.
    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (accept_start_s) begin
            sat_cnt_d = {SAT_W{1'b0}};
        end else if (s1_valid_q) begin
            sat_cnt_d = sat_cnt_q + SAT_W'(s1_sat_q);
        end else begin
            sat_cnt_d = sat_cnt_q;
        end
    end

    // Saturation state registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            s1_sat_q  <= 3'd0;
            sat_cnt_q <= {SAT_W{1'b0}};
        end else begin
            s1_sat_q  <= s1_sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_count = sat_cnt_q;
`endif

    // All remaining state registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'b00;
            bright_q     <= 8'd0;
            pair_cnt_q   <= {CNT_W{1'b0}};
            s1_valid_q   <= 1'b0;
            s1_pix_q     <= 48'd0;
            hsync_q      <= 1'b0;
            dout_q       <= 48'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            out_col_q    <= {COL_W{1'b0}};
            out_row_q    <= {ROW_W{1'b0}};
            col_idx_q    <= {COL_W{1'b0}};
            row_idx_q    <= {ROW_W{1'b0}};
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            bright_q     <= bright_d;
            pair_cnt_q   <= pair_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_pix_q     <= s1_pix_d;
            hsync_q      <= hsync_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            out_col_q    <= out_col_d;
            out_row_q    <= out_row_d;
            col_idx_q    <= col_idx_d;
            row_idx_q    <= row_idx_d;
        end
    end

    assign hsync      = hsync_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign col_idx    = col_idx_q;
    assign row_idx    = row_idx_q;
    assign {DATA_WRITE_R0, DATA_WRITE_G0, DATA_WRITE_B0, DATA_WRITE_R1, DATA_WRITE_G1, DATA_WRITE_B1} = dout_q;

endmodule
